dsram_like_resp: RTL

Data-side SRAM-like bus responder. It is the slave end of the request/`addr_ok`/`data_ok` protocol driven by the execute stage's data-access port. It acts as a behavioural data memory for core bring-up and pipeline verification: it accepts requests, keeps an in-order queue of outstanding transactions, and returns `data_ok` plus read data after a fixed latency. It sits between the EX/MEM data port and a word-organised on-chip RAM array.

---
 rtl/dsram_like_resp_pkg.sv | 29 ++
 rtl/dsram_like_resp_if.sv | 33 +++
 rtl/dsram_resp_fifo.sv | 85 ++++++++
 rtl/dsram_like_resp.sv | 92 +++++++++
 4 files changed

// File: rtl/dsram_like_resp_pkg.sv
// Shared definitions for the data-side SRAM-like responder:
// size encodings, response queue entry layout, and LFSR constants.
package dsram_like_resp_pkg;

  // Access size encodings carried on data_sram_size.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Response queue entry: {is_wr, rdata, timer}.
  localparam int TIMER_W = 8;
  localparam int RDATA_W = 32;
  localparam int ENTRY_W = 1 + RDATA_W + TIMER_W;

  typedef struct packed {
    logic               is_wr;
    logic [RDATA_W-1:0] rdata;
    logic [TIMER_W-1:0] timer;
  } entry_t;

  // Back-pressure LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dsram_like_resp_if.sv
// Data-side SRAM-like bus between the EX/MEM data port (master) and
// the responder (slave).
//
// Handshake: a request is accepted on a rising edge where
// data_sram_req && data_sram_addr_ok; the master holds all request fields
// stable while req is high and addr_ok is low. data_sram_data_ok has no
// ready: each pulse is one response, oldest accepted transaction first,
// and data_sram_rdata is meaningful only while data_ok is high.
interface dsram_like_resp_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/dsram_resp_fifo.sv
// Timer-tagged in-order response queue. Each entry counts down from
// LAT-1 after push; the head pops itself in the cycle its timer is zero.
module dsram_resp_fifo
  import dsram_like_resp_pkg::*;
#(
  parameter int LAT     = 2,
  parameter int Q_DEPTH = 2,
  localparam int PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1,
  localparam int CNT_W  = $clog2(Q_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  output logic             head_ok_o,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t             mem_q [Q_DEPTH];
  entry_t             mem_d [Q_DEPTH];
  logic [Q_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop;

  // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(Q_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign pop       = valid_q[rd_ptr_q] && (mem_q[rd_ptr_q].timer == '0);
  assign head_ok_o = pop;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next-state: age every live entry, retire the ready head, insert the push.
  always_comb begin
    valid_d  = valid_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop);
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].timer != '0)) begin
        mem_d[i].timer = mem_q[i].timer - TIMER_W'(1);
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = inc_ptr(rd_ptr_q);
    end
    if (push_i) begin
      valid_d[wr_ptr_q]     = 1'b1;
      mem_d[wr_ptr_q]       = push_entry_i;
      mem_d[wr_ptr_q].timer = TIMER_W'(LAT - 1);
      wr_ptr_d              = inc_ptr(wr_ptr_q);
    end
  end

  // Control state; reset discards all outstanding entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payloads are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Q_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/dsram_like_resp.sv
// Behavioural data-side SRAM-like responder: word RAM with byte-lane
// writes, in-order fixed-latency responses via dsram_resp_fifo.
// Optional random back-pressure when DSRAM_STALL_EN is defined.
module dsram_like_resp
  import dsram_like_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2,
  parameter int Q_DEPTH    = 2,
  localparam int CNT_W     = $clog2(Q_DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  dsram_like_resp_if.slave  bus
);

  logic [31:0]           ram_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  accept;
  logic                  addr_ok;
  logic                  stall_ok;
  logic                  run_q;
  logic [CNT_W-1:0]      count;
  logic                  head_ok;
  entry_t                head;
  entry_t                push_entry;
  logic                  unused_bits;

  assign word_idx = bus.data_sram_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running back-pressure source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  // Holds addr_ok low while in reset; only registered state feeds addr_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign addr_ok = run_q && stall_ok && (count < CNT_W'(Q_DEPTH));
  assign accept  = bus.data_sram_req && addr_ok;

  // Byte-lane writes; size is informational, wstrb alone selects lanes.
  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wstrb[i]) begin
          ram_q[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Reads snapshot the word at accept, after every earlier write landed.
  always_comb begin
    push_entry       = '0;
    push_entry.is_wr = bus.data_sram_wr;
    push_entry.rdata = bus.data_sram_wr ? 32'h0 : ram_q[word_idx];
  end

  dsram_resp_fifo #(
    .LAT     (LAT),
    .Q_DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .head_ok_o    (head_ok),
    .head_o       (head),
    .count_o      (count)
  );

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = head_ok;
  assign bus.data_sram_rdata   = (head_ok && !head.is_wr) ? head.rdata : 32'h0;

  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:DEPTH_LOG2+2],
                         bus.data_sram_addr[1:0], head.timer};

endmodule
